// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared constants and types for the PS/2 keyboard front end and the maze
// movement stage that consumes key_code.
//   PS2_EXT / PS2_BREAK : prefix bytes of the PS/2 scan-code set 2
//   KEY_*               : 7-bit scan codes of the arrow keys (used with ext=1)
//   rx_state_t          : frame receiver states
//   dec_state_t         : decoder prefix state, encoded as {ext, brk}
// ---------------------------------------------------------------------------
package maze_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [6:0] KEY_LEFT  = 7'h6B;
  localparam logic [6:0] KEY_RIGHT = 7'h74;
  localparam logic [6:0] KEY_UP    = 7'h75;
  localparam logic [6:0] KEY_DOWN  = 7'h72;

  localparam int DEFAULT_FILTER_LEN = 8;
  localparam int DEFAULT_TIMEOUT    = 50_000;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Bit 1 is the extended-prefix flag, bit 0 the break-prefix flag, so the
  // flags can be read straight off the state register.
  typedef enum logic [1:0] {
    DEC_IDLE    = 2'b00,
    DEC_BRK     = 2'b01,
    DEC_EXT     = 2'b10,
    DEC_EXT_BRK = 2'b11
  } dec_state_t;

  // True when data+parity carry an odd number of ones (a good PS/2 frame).
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: synchronises the raw pins, debounces the PS/2 clock,
// shifts in start/8 data/parity/stop and aborts a stalled frame.
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   rx_byte    out  last good byte, valid while rx_strobe is high
//   rx_strobe  out  one-cycle pulse per good frame
//   frame_err  out  one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_rx
  import maze_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] to_cnt;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive sample that
  // disagrees with it; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync != filt_clk) begin
      if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Falling edge is flagged in the same cycle the filtered clock drops.
  assign fall = filt_clk & ~clk_sync & (filt_cnt == FW'(FILTER_LEN - 1));

  // A data edge takes priority over timeout expiry, so a stop bit that
  // lands on the last timeout cycle still completes the frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (state == RX_IDLE) begin
        to_cnt <= '0;
        if (fall && !data_sync) begin
          state   <= RX_DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          RX_DATA: begin
            shift   <= {data_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok <= odd_parity_ok({data_sync, shift});
            state     <= RX_STOP;
          end
          default: begin
            state <= RX_IDLE;
            if (data_sync && parity_ok) begin
              rx_byte   <= shift;
              rx_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        state     <= RX_IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 make/break scan-code sequences into a held key code for the
// maze movement stage.
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   ps2_clk    in   raw PS/2 clock pin
//   ps2_data   in   raw PS/2 data pin
//   key_code   out  {ext, scan[6:0]} of the held key, 0x00 when none
//   key_valid  out  one-cycle pulse per accepted make code
//   frame_err  out  one-cycle pulse on any receive error
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import maze_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  dec_state_t dec_state;
  logic       ext, brk;
  logic [7:0] code;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err)
  );

  assign ext  = dec_state[1];
  assign brk  = dec_state[0];
  assign code = {ext, rx_byte[6:0]};

  // Prefix bytes only set flags; any other byte consumes and clears them.
  // A break only clears key_code when it names the key currently held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_state <= DEC_IDLE;
      key_code  <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (rx_strobe) begin
        if (rx_byte == PS2_EXT) begin
          dec_state <= dec_state_t'({1'b1, brk});
        end else if (rx_byte == PS2_BREAK) begin
          dec_state <= dec_state_t'({ext, 1'b1});
        end else begin
          dec_state <= DEC_IDLE;
          if (!rx_byte[7]) begin
            if (brk) begin
              if (code == key_code) key_code <= 8'h00;
            end else begin
              key_code  <= code;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames on the raw pins
// and compares key_code / pulse counts with hand-derived values.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int TB_FILTER  = 8;
  localparam int TB_TIMEOUT = 1000;
  localparam int HALF       = 20;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;

  int checks = 0;
  int fails  = 0;
  int kv_count  = 0;
  int err_count = 0;

  ps2_key_decoder #(
    .FILTER_LEN(TB_FILTER),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters let each test check "exactly one pulse" as a delta.
  always @(posedge clk) begin
    if (key_valid === 1'b1) kv_count++;
    if (frame_err === 1'b1) err_count++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit cell: data set while clock high, then a low half period.
  // With glitch set, short opposite-level pulses are injected in both halves.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_clks(5); ps2_clk = 1'b0; wait_clks(3); ps2_clk = 1'b1; wait_clks(HALF - 8);
    end else begin
      wait_clks(HALF);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_clks(5); ps2_clk = 1'b1; wait_clks(3); ps2_clk = 1'b0; wait_clks(HALF - 8);
    end else begin
      wait_clks(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity,
                            input bit bad_stop, input bit glitch);
    logic [10:0] bits;
    logic par;
    par  = ~(^b) ^ bad_parity;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    ps2_data = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
  endtask

  task automatic test_reset;
    checks++;
    if (key_code !== 8'h00) begin
      fails++; $display("[TB] FAIL reset_key_code: got %h expected 00", key_code);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_arrow;
    int kv0;
    kv0 = kv_count;
    send_byte(8'hE0); send_byte(8'h75);
    checks++;
    if (key_code !== 8'hF5) begin
      fails++; $display("[TB] FAIL arrow_make: got %h expected F5", key_code);
    end
    checks++;
    if (kv_count - kv0 !== 1) begin
      fails++; $display("[TB] FAIL arrow_make_valid: got %0d pulses expected 1", kv_count - kv0);
    end
    kv0 = kv_count;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++;
    if (key_code !== 8'h00) begin
      fails++; $display("[TB] FAIL arrow_break: got %h expected 00", key_code);
    end
    checks++;
    if (kv_count - kv0 !== 0) begin
      fails++; $display("[TB] FAIL arrow_break_valid: got %0d pulses expected 0", kv_count - kv0);
    end
  endtask

  task automatic test_make_break;
    send_byte(8'h1C);
    checks++;
    if (key_code !== 8'h1C) begin
      fails++; $display("[TB] FAIL plain_make: got %h expected 1C", key_code);
    end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++;
    if (key_code !== 8'h00) begin
      fails++; $display("[TB] FAIL plain_break: got %h expected 00", key_code);
    end
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h32);
    checks++;
    if (key_code !== 8'h1C) begin
      fails++; $display("[TB] FAIL other_break: got %h expected 1C", key_code);
    end
  endtask

  task automatic test_errors;
    int e0, kv0;
    e0 = err_count; kv0 = kv_count;
    send_frame(8'h6B, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count - e0 !== 1) begin
      fails++; $display("[TB] FAIL parity_err: got %0d pulses expected 1", err_count - e0);
    end
    checks++;
    if (key_code !== 8'h1C) begin
      fails++; $display("[TB] FAIL parity_keep: got %h expected 1C", key_code);
    end
    e0 = err_count;
    send_frame(8'h6B, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_count - e0 !== 1) begin
      fails++; $display("[TB] FAIL stop_err: got %0d pulses expected 1", err_count - e0);
    end
    checks++;
    if (key_code !== 8'h1C || kv_count != kv0) begin
      fails++; $display("[TB] FAIL stop_keep: got %h/%0d expected 1C/0", key_code, kv_count - kv0);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_count;
    send_partial(8'h6B, 4);
    wait_clks(TB_TIMEOUT + 10);
    checks++;
    if (err_count - e0 !== 1) begin
      fails++; $display("[TB] FAIL timeout_err: got %0d pulses expected 1", err_count - e0);
    end
    wait_clks(TB_TIMEOUT + 10);
    checks++;
    if (err_count - e0 !== 1) begin
      fails++; $display("[TB] FAIL timeout_once: got %0d pulses expected 1", err_count - e0);
    end
    ps2_data = 1'b1;
    send_byte(8'hE0); send_byte(8'h6B);
    checks++;
    if (key_code !== 8'hEB) begin
      fails++; $display("[TB] FAIL timeout_recover: got %h expected EB", key_code);
    end
  endtask

  task automatic test_glitch;
    int e0, kv0;
    e0 = err_count; kv0 = kv_count;
    send_frame(8'h2D, 1'b0, 1'b0, 1'b1);
    checks++;
    if (key_code !== 8'h2D) begin
      fails++; $display("[TB] FAIL glitch_byte: got %h expected 2D", key_code);
    end
    checks++;
    if (err_count != e0 || kv_count - kv0 != 1) begin
      fails++; $display("[TB] FAIL glitch_pulses: got err %0d valid %0d expected 0/1",
                        err_count - e0, kv_count - kv0);
    end
  endtask

  task automatic test_reset_midframe;
    int kv0;
    send_byte(8'hE0); send_byte(8'h72);
    checks++;
    if (key_code !== 8'hF2) begin
      fails++; $display("[TB] FAIL pre_reset_key: got %h expected F2", key_code);
    end
    send_partial(8'h1C, 3);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (key_code !== 8'h00) begin
      fails++; $display("[TB] FAIL midframe_reset: got %h expected 00", key_code);
    end
    ps2_data = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(20);
    kv0 = kv_count;
    send_byte(8'hAA);
    checks++;
    if (key_code !== 8'h00 || kv_count != kv0) begin
      fails++; $display("[TB] FAIL bat_ignored: got %h/%0d expected 00/0", key_code, kv_count - kv0);
    end
    send_byte(8'h1C);
    checks++;
    if (key_code !== 8'h1C) begin
      fails++; $display("[TB] FAIL post_reset_frame: got %h expected 1C", key_code);
    end
    send_byte(8'hE0); send_byte(8'hAA); send_byte(8'h29);
    checks++;
    if (key_code !== 8'h29) begin
      fails++; $display("[TB] FAIL ignored_clears_ext: got %h expected 29", key_code);
    end
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    test_reset;
    reset = 1'b1;
    wait_clks(20);
    $display("[TB] arrow make/break");
    test_arrow;
    $display("[TB] plain make/break");
    test_make_break;
    $display("[TB] parity and stop errors");
    test_errors;
    $display("[TB] timeout");
    test_timeout;
    $display("[TB] clock glitches");
    test_glitch;
    $display("[TB] reset mid-frame");
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
